// File: rtl/vend_output_ctrl_if.sv
// rtl/vend_output_ctrl_if.sv - FSM-side and physical-output bundle for the vending output stage
// Optional coin counter signals appear when VEND_COIN_COUNT_EN is defined.
interface vend_out_if #(
  parameter int N_PROD = 4,
  parameter int CHG_W  = 8,
  parameter int SEL_W  = (N_PROD > 1) ? $clog2(N_PROD) : 1
);
  logic [2:0]        fsm_state;
  logic [SEL_W-1:0]  product_sel;
  logic [CHG_W-1:0]  change_amt;
  logic [N_PROD-1:0] dispense;
  logic              coin_q;
  logic              coin_d;
  logic              coin_n;
  logic              busy;
  logic              op_done;
  logic              fault;
`ifdef VEND_COIN_COUNT_EN
  logic [7:0]        cnt_q;
  logic [7:0]        cnt_d;
  logic [7:0]        cnt_n;

  modport master (output fsm_state, product_sel, change_amt,
                  input  dispense, coin_q, coin_d, coin_n, busy, op_done, fault,
                         cnt_q, cnt_d, cnt_n);
  modport slave  (input  fsm_state, product_sel, change_amt,
                  output dispense, coin_q, coin_d, coin_n, busy, op_done, fault,
                         cnt_q, cnt_d, cnt_n);
`else
  modport master (output fsm_state, product_sel, change_amt,
                  input  dispense, coin_q, coin_d, coin_n, busy, op_done, fault);
  modport slave  (input  fsm_state, product_sel, change_amt,
                  output dispense, coin_q, coin_d, coin_n, busy, op_done, fault);
`endif
endinterface

// File: rtl/vend_output_ctrl.sv
// rtl/vend_output_ctrl.sv - timed dispense pulse and greedy coin ejection for the vending FSM
// VEND_COIN_COUNT_EN adds saturating per-coin pulse counters.
module vend_output_ctrl #(
  parameter int N_PROD      = 4,
  parameter int CHG_W       = 8,
  parameter int DISP_CYCLES = 4,
  parameter int COIN_CYCLES = 2,
  parameter int ST_DISPENSE = 4,
  parameter int ST_CHANGE   = 5
) (
  input logic      clk,
  input logic      rst,
  vend_out_if.slave bus
);
  localparam int TMR_MAX = (DISP_CYCLES > COIN_CYCLES) ? DISP_CYCLES : COIN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {IDLE, DISP, CHG, COIN, GAP, DONE} state_t;

  state_t            state_q;
  logic [2:0]        prev_state_q;
  logic              armed_q;
  logic [CHG_W-1:0]  rem_q;
  logic [TMR_W-1:0]  timer_q;
  logic [N_PROD-1:0] dispense_q;
  logic              coin_q_q, coin_d_q, coin_n_q;
  logic              busy_q, op_done_q, fault_q;
`ifdef VEND_COIN_COUNT_EN
  logic [7:0]        qcnt_q, dcnt_q, ncnt_q;
`endif

  logic [31:0]       sel_ext_d;
  logic [31:0]       rem_ext_d;
  logic [N_PROD-1:0] sel_onehot_d;
  logic              trigger_d;

  // Decode against the full input width so out-of-range indices yield an empty vector.
  always_comb begin
    sel_ext_d    = 32'(bus.product_sel);
    rem_ext_d    = 32'(rem_q);
    sel_onehot_d = '0;
    for (int i = 0; i < N_PROD; i++) begin
      sel_onehot_d[i] = (sel_ext_d == 32'(i));
    end
    trigger_d = (state_q == IDLE) && armed_q && (bus.fsm_state != prev_state_q) &&
                ((bus.fsm_state == 3'(ST_DISPENSE)) || (bus.fsm_state == 3'(ST_CHANGE)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_state_q <= '0;
      armed_q      <= 1'b0;
      rem_q        <= '0;
      timer_q      <= '0;
      dispense_q   <= '0;
      coin_q_q     <= 1'b0;
      coin_d_q     <= 1'b0;
      coin_n_q     <= 1'b0;
      busy_q       <= 1'b0;
      op_done_q    <= 1'b0;
      fault_q      <= 1'b0;
`ifdef VEND_COIN_COUNT_EN
      qcnt_q       <= '0;
      dcnt_q       <= '0;
      ncnt_q       <= '0;
`endif
    end else begin
      prev_state_q <= bus.fsm_state;
      armed_q      <= 1'b1;
      op_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trigger_d) begin
            busy_q <= 1'b1;
            if (bus.fsm_state == 3'(ST_DISPENSE)) begin
              state_q    <= DISP;
              dispense_q <= sel_onehot_d;
              fault_q    <= ~|sel_onehot_d;
              timer_q    <= TMR_W'(DISP_CYCLES - 1);
            end else begin
              state_q <= CHG;
              rem_q   <= bus.change_amt;
              fault_q <= 1'b0;
            end
          end
        end
        DISP: begin
          if (timer_q == '0) begin
            dispense_q <= '0;
            op_done_q  <= 1'b1;
            state_q    <= DONE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        CHG: begin
          timer_q <= TMR_W'(COIN_CYCLES - 1);
          if (rem_ext_d >= 32'd25) begin
            rem_q    <= rem_q - CHG_W'(25);
            coin_q_q <= 1'b1;
            state_q  <= COIN;
`ifdef VEND_COIN_COUNT_EN
            if (qcnt_q != 8'hFF) qcnt_q <= qcnt_q + 8'd1;
`endif
          end else if (rem_ext_d >= 32'd10) begin
            rem_q    <= rem_q - CHG_W'(10);
            coin_d_q <= 1'b1;
            state_q  <= COIN;
`ifdef VEND_COIN_COUNT_EN
            if (dcnt_q != 8'hFF) dcnt_q <= dcnt_q + 8'd1;
`endif
          end else if (rem_ext_d >= 32'd5) begin
            rem_q    <= rem_q - CHG_W'(5);
            coin_n_q <= 1'b1;
            state_q  <= COIN;
`ifdef VEND_COIN_COUNT_EN
            if (ncnt_q != 8'hFF) ncnt_q <= ncnt_q + 8'd1;
`endif
          end else begin
            // A residue below a nickel cannot be paid out; flag it and drop it.
            fault_q   <= (rem_q != '0);
            rem_q     <= '0;
            op_done_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        COIN: begin
          if (timer_q == '0) begin
            coin_q_q <= 1'b0;
            coin_d_q <= 1'b0;
            coin_n_q <= 1'b0;
            timer_q  <= TMR_W'(COIN_CYCLES - 1);
            state_q  <= GAP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        GAP: begin
          if (timer_q == '0) state_q <= CHG;
          else               timer_q <= timer_q - 1'b1;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dispense = dispense_q;
  assign bus.coin_q   = coin_q_q;
  assign bus.coin_d   = coin_d_q;
  assign bus.coin_n   = coin_n_q;
  assign bus.busy     = busy_q;
  assign bus.op_done  = op_done_q;
  assign bus.fault    = fault_q;
`ifdef VEND_COIN_COUNT_EN
  assign bus.cnt_q    = qcnt_q;
  assign bus.cnt_d    = dcnt_q;
  assign bus.cnt_n    = ncnt_q;
`endif
endmodule

// File: tb/tb_vend_output_ctrl.sv
// tb/tb_vend_output_ctrl.sv - scoreboard bench for vend_output_ctrl
// Product select is widened to 3 bits so an out-of-range index can be driven.
module tb_vend_output_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vend_out_if #(.N_PROD(4), .CHG_W(8), .SEL_W(3)) bus ();

  vend_output_ctrl #(
    .N_PROD(4), .CHG_W(8), .DISP_CYCLES(4), .COIN_CYCLES(2),
    .ST_DISPENSE(4), .ST_CHANGE(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {dispense[3:0], coin_q, coin_d, coin_n, busy, op_done, fault}
  logic [9:0] exp_q[$];
  logic       exp_fault = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  string      tag = "reset";

  function automatic logic [9:0] mk(logic [3:0] d, logic [2:0] c, logic b, logic o, logic f);
    return {d, c, b, o, f};
  endfunction

  function automatic logic [9:0] observed();
    return {bus.dispense, bus.coin_q, bus.coin_d, bus.coin_n, bus.busy, bus.op_done, bus.fault};
  endfunction

  task automatic check(input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s t=%0t observed=%b expected=%b", tag, $time, obs, exp);
    end
  endtask

  task automatic tick();
    logic [9:0] e;
    @(posedge clk);
    #1;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : mk(4'b0, 3'b0, 1'b0, 1'b0, exp_fault);
    check(observed(), e);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic push_disp(input int sel);
    logic [3:0] oh;
    logic       f;
    oh = (sel < 4) ? 4'(1 << sel) : 4'b0;
    f  = (sel >= 4);
    repeat (4) exp_q.push_back(mk(oh, 3'b0, 1'b1, 1'b0, f));
    exp_q.push_back(mk(4'b0, 3'b0, 1'b1, 1'b1, f));
    exp_fault = f;
  endtask

  task automatic push_chg(input int amt);
    int         rem;
    logic [2:0] c;
    logic       f;
    rem = amt;
    while (rem >= 5) begin
      if (rem >= 25)      begin c = 3'b100; rem -= 25; end
      else if (rem >= 10) begin c = 3'b010; rem -= 10; end
      else                begin c = 3'b001; rem -= 5;  end
      exp_q.push_back(mk(4'b0, 3'b0, 1'b1, 1'b0, 1'b0));
      repeat (2) exp_q.push_back(mk(4'b0, c, 1'b1, 1'b0, 1'b0));
      repeat (2) exp_q.push_back(mk(4'b0, 3'b0, 1'b1, 1'b0, 1'b0));
    end
    exp_q.push_back(mk(4'b0, 3'b0, 1'b1, 1'b0, 1'b0));
    f = (rem != 0);
    exp_q.push_back(mk(4'b0, 3'b0, 1'b1, 1'b1, f));
    exp_fault = f;
  endtask

  task automatic trig_disp(input int sel);
    bus.fsm_state = 3'd0;
    tick();
    bus.fsm_state   = 3'd4;
    bus.product_sel = 3'(sel);
    push_disp(sel);
    tick();
  endtask

  task automatic trig_chg(input int amt);
    bus.fsm_state = 3'd0;
    tick();
    bus.fsm_state  = 3'd5;
    bus.change_amt = 8'(amt);
    push_chg(amt);
    tick();
  endtask

  initial begin
    bus.fsm_state   = 3'd0;
    bus.product_sel = 3'd0;
    bus.change_amt  = 8'd0;
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    tag = "idle";
    run(2);

    tag = "disp_sel2";
    trig_disp(2);
    run(6);

    tag = "chg_40";
    trig_chg(40);
    run(18);

    tag = "chg_0";
    trig_chg(0);
    run(3);

    tag = "chg_7";
    trig_chg(7);
    run(9);

    tag = "chg_clear";
    trig_chg(0);
    run(3);

    tag = "disp_sel5";
    trig_disp(5);
    run(6);

    tag = "disp_retrig";
    trig_disp(1);
    tick();
    bus.fsm_state  = 3'd5;
    bus.change_amt = 8'd40;
    run(8);

    tag = "chg_rst";
    trig_chg(40);
    tick();
    rst = 1'b1;
    #1;
    tag = "async_drop";
    check(observed(), 10'b0);
    exp_q.delete();
    exp_fault = 1'b0;
    tag = "in_reset";
    run(2);
    rst = 1'b0;
    tag = "no_retrig";
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
